// File: rtl/flu_wb_scheduler.sv
// Issue-side scheduler for the shared fixed-latency writeback port.
// Grants one issue per cycle into a free result slot and exposes the slot owning the port.
module flu_wb_scheduler #(
    parameter  int unsigned NR_REQ        = 4,
    parameter  int unsigned MAX_LAT       = 4,
    parameter  int unsigned TRANS_ID_BITS = 3,
    localparam int unsigned LAT_W         = $clog2(MAX_LAT + 1),
    localparam int unsigned SRC_W         = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              stall_i,
    input  logic [NR_REQ-1:0]                 req_i,
    input  logic [NR_REQ*LAT_W-1:0]           req_lat_i,
    input  logic [NR_REQ*TRANS_ID_BITS-1:0]   req_tid_i,
    output logic [NR_REQ-1:0]                 gnt_o,
    output logic                              wb_valid_o,
    output logic [SRC_W-1:0]                  wb_src_o,
    output logic [TRANS_ID_BITS-1:0]          wb_trans_id_o,
    output logic                              busy_o,
    output logic                              lat_err_o
);

    logic [MAX_LAT-1:0]       slot_v;
    logic [SRC_W-1:0]         slot_src [MAX_LAT];
    logic [TRANS_ID_BITS-1:0] slot_tid [MAX_LAT];
    logic [SRC_W-1:0]         rr;
    logic                     lat_err;

    logic [NR_REQ-1:0]        elig;
    logic [NR_REQ-1:0]        lat_bad;
    logic                     found;
    logic                     grant;
    logic [SRC_W-1:0]         gnt_idx;
    logic [LAT_W-1:0]         gnt_lat;
    logic [TRANS_ID_BITS-1:0] gnt_tid;
    logic [NR_REQ-1:0]        gnt;

    // Eligibility: legal latency and target slot free after the coming shift.
    // s[MAX_LAT] does not exist, so latency MAX_LAT is never blocked.
    always_comb begin
        elig    = '0;
        lat_bad = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            logic [LAT_W-1:0] lat;
            logic             legal;
            logic             occ;
            lat   = req_lat_i[i*LAT_W +: LAT_W];
            legal = (lat != '0) && (lat <= LAT_W'(MAX_LAT));
            occ   = 1'b0;
            for (int unsigned k = 1; k < MAX_LAT; k++) begin
                if (lat == LAT_W'(k) && slot_v[k])
                    occ = 1'b1;
            end
            elig[i]    = req_i[i] && legal && !occ;
            lat_bad[i] = req_i[i] && !legal;
        end
    end

    // Round-robin scan starting at rr, wrapping past NR_REQ-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned off = 0; off < NR_REQ; off++) begin
            int unsigned idx;
            idx = (int'(rr) + off) % NR_REQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = SRC_W'(idx);
            end
        end
        grant   = found && !flush_i && !stall_i && !rst_i;
        gnt_lat = req_lat_i[int'(gnt_idx)*LAT_W +: LAT_W];
        gnt_tid = req_tid_i[int'(gnt_idx)*TRANS_ID_BITS +: TRANS_ID_BITS];
        gnt     = '0;
        if (grant)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_v  <= '0;
            rr      <= '0;
            lat_err <= 1'b0;
            for (int unsigned k = 0; k < MAX_LAT; k++) begin
                slot_src[k] <= '0;
                slot_tid[k] <= '0;
            end
        end else begin
            if (|lat_bad)
                lat_err <= 1'b1;
            if (flush_i) begin
                slot_v <= '0;
                for (int unsigned k = 0; k < MAX_LAT; k++) begin
                    slot_src[k] <= '0;
                    slot_tid[k] <= '0;
                end
            end else begin
                for (int unsigned k = 0; k < MAX_LAT; k++) begin
                    if (k + 1 < MAX_LAT) begin
                        slot_v[k]   <= slot_v[k+1];
                        slot_src[k] <= slot_src[k+1];
                        slot_tid[k] <= slot_tid[k+1];
                    end else begin
                        slot_v[k]   <= 1'b0;
                        slot_src[k] <= '0;
                        slot_tid[k] <= '0;
                    end
                end
                // New entry lands in s[L-1]; overrides the shift into that slot.
                if (grant) begin
                    for (int unsigned k = 0; k < MAX_LAT; k++) begin
                        if (gnt_lat == LAT_W'(k + 1)) begin
                            slot_v[k]   <= 1'b1;
                            slot_src[k] <= gnt_idx;
                            slot_tid[k] <= gnt_tid;
                        end
                    end
                    rr <= (int'(gnt_idx) == NR_REQ - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    assign gnt_o         = gnt;
    assign wb_valid_o    = slot_v[0];
    assign wb_src_o      = slot_v[0] ? slot_src[0] : '0;
    assign wb_trans_id_o = slot_v[0] ? slot_tid[0] : '0;
    assign busy_o        = |slot_v;
    assign lat_err_o     = lat_err;

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Directed self-checking bench for flu_wb_scheduler (NR_REQ=4, MAX_LAT=4, TRANS_ID_BITS=3).
module tb_flu_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [3:0]  req;
    logic [11:0] req_lat;
    logic [11:0] req_tid;
    logic [3:0]  gnt;
    logic        wb_valid;
    logic [1:0]  wb_src;
    logic [2:0]  wb_tid;
    logic        busy;
    logic        lat_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flu_wb_scheduler #(
        .NR_REQ        (4),
        .MAX_LAT       (4),
        .TRANS_ID_BITS (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .stall_i       (stall),
        .req_i         (req),
        .req_lat_i     (req_lat),
        .req_tid_i     (req_tid),
        .gnt_o         (gnt),
        .wb_valid_o    (wb_valid),
        .wb_src_o      (wb_src),
        .wb_trans_id_o (wb_tid),
        .busy_o        (busy),
        .lat_err_o     (lat_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_unit(input int u, input logic r, input logic [2:0] lat, input logic [2:0] tid);
        req[u]           = r;
        req_lat[u*3 +: 3] = lat;
        req_tid[u*3 +: 3] = tid;
    endtask

    task automatic clear_inputs();
        req     = '0;
        req_lat = '0;
        req_tid = '0;
        flush   = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [1:0] src, input logic [2:0] tid);
        check({tag, "_valid"}, wb_valid, v);
        check({tag, "_src"}, wb_src, src);
        check({tag, "_tid"}, wb_tid, tid);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_wb("rst", 1'b0, 2'd0, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_laterr", lat_err, 1'b0);
        check("rst_gnt", gnt, 4'b0000);

        // 1: single lat=1 issue
        set_unit(0, 1'b1, 3'd1, 3'd5);
        settle();
        check("t1_gnt", gnt, 4'b0001);
        next_cycle(); clear_inputs(); settle();
        check_wb("t1_wb1", 1'b1, 2'd0, 3'd5);
        check("t1_busy1", busy, 1'b1);
        next_cycle(); settle();
        check("t1_valid2", wb_valid, 1'b0);
        check("t1_busy2", busy, 1'b0);

        // 2: slot collision blocks a later lat=1 request
        do_reset();
        set_unit(2, 1'b1, 3'd3, 3'd2);
        settle();
        check("t2_gnt0", gnt, 4'b0100);
        next_cycle(); clear_inputs(); settle();
        next_cycle(); set_unit(0, 1'b1, 3'd1, 3'd6); settle();
        check("t2_gnt2_blocked", gnt, 4'b0000);
        next_cycle(); settle();
        check("t2_gnt3", gnt, 4'b0001);
        check_wb("t2_wb3", 1'b1, 2'd2, 3'd2);
        next_cycle(); clear_inputs(); settle();
        check_wb("t2_wb4", 1'b1, 2'd0, 3'd6);

        // 3: round-robin between two lat=1 requesters
        do_reset();
        set_unit(0, 1'b1, 3'd1, 3'd1);
        set_unit(1, 1'b1, 3'd1, 3'd2);
        settle();
        check("t3_gnt0", gnt, 4'b0001);
        next_cycle(); settle();
        check("t3_gnt1", gnt, 4'b0010);
        check_wb("t3_wb1", 1'b1, 2'd0, 3'd1);
        next_cycle(); settle();
        check("t3_gnt2", gnt, 4'b0001);
        check_wb("t3_wb2", 1'b1, 2'd1, 3'd2);
        next_cycle(); settle();
        check("t3_gnt3", gnt, 4'b0010);
        check_wb("t3_wb3", 1'b1, 2'd0, 3'd1);
        next_cycle(); clear_inputs(); settle();
        check_wb("t3_wb4", 1'b1, 2'd1, 3'd2);

        // 4: flush kills lat=2 and lat=4 entries
        do_reset();
        set_unit(1, 1'b1, 3'd2, 3'd3);
        settle();
        check("t4_gnt0", gnt, 4'b0010);
        next_cycle(); clear_inputs(); set_unit(3, 1'b1, 3'd4, 3'd4); settle();
        check("t4_gnt1", gnt, 4'b1000);
        next_cycle(); clear_inputs(); flush = 1'b1; set_unit(0, 1'b1, 3'd1, 3'd0); settle();
        check("t4_gnt_flush", gnt, 4'b0000);
        check_wb("t4_wb_flush", 1'b1, 2'd1, 3'd3);
        next_cycle(); clear_inputs(); settle();
        check("t4_valid3", wb_valid, 1'b0);
        check("t4_busy3", busy, 1'b0);
        next_cycle(); settle();
        next_cycle(); settle();
        check("t4_valid5", wb_valid, 1'b0);
        check("t4_busy5", busy, 1'b0);

        // 5: illegal latencies
        do_reset();
        set_unit(1, 1'b1, 3'd0, 3'd1);
        set_unit(0, 1'b1, 3'd1, 3'd7);
        settle();
        check("t5_gnt0", gnt, 4'b0001);
        check("t5_laterr0", lat_err, 1'b0);
        next_cycle(); settle();
        check("t5_gnt1", gnt, 4'b0001);
        check("t5_laterr1", lat_err, 1'b1);
        next_cycle(); clear_inputs(); set_unit(1, 1'b1, 3'd5, 3'd1); settle();
        check("t5_gnt2", gnt, 4'b0000);
        next_cycle(); clear_inputs(); settle();
        check("t5_laterr3", lat_err, 1'b1);
        do_reset();
        check("t5_laterr_rst", lat_err, 1'b0);

        // 6: stall keeps draining, then reset mid-flight
        set_unit(2, 1'b1, 3'd3, 3'd1);
        settle();
        check("t6_gnt0", gnt, 4'b0100);
        next_cycle(); clear_inputs(); stall = 1'b1; set_unit(0, 1'b1, 3'd1, 3'd2); settle();
        check("t6_gnt1", gnt, 4'b0000);
        next_cycle(); settle();
        check("t6_gnt2", gnt, 4'b0000);
        next_cycle(); settle();
        check("t6_gnt3", gnt, 4'b0000);
        check_wb("t6_wb3", 1'b1, 2'd2, 3'd1);
        next_cycle(); stall = 1'b0; settle();
        check("t6_gnt4", gnt, 4'b0001);
        next_cycle(); clear_inputs(); set_unit(3, 1'b1, 3'd4, 3'd5); settle();
        check_wb("t6_wb5", 1'b1, 2'd0, 3'd2);
        check("t6_gnt5", gnt, 4'b1000);
        next_cycle(); clear_inputs(); rst = 1'b1; set_unit(0, 1'b1, 3'd1, 3'd3); settle();
        check("t6_gnt_rst", gnt, 4'b0000);
        next_cycle(); rst = 1'b0; clear_inputs(); settle();
        check_wb("t6_wb7", 1'b0, 2'd0, 3'd0);
        check("t6_busy7", busy, 1'b0);
        check("t6_laterr7", lat_err, 1'b0);
        next_cycle(); settle();
        next_cycle(); settle();
        check("t6_valid9", wb_valid, 1'b0);
        check("t6_busy9", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
